// File: rtl/servo_pwm_multi_if.sv
// Command/status bundle between control logic and the multi-channel servo pulse generator.
// i_* signals are driven by the master (control side), o_* by the slave (pulse generator).
interface servo_pwm_multi_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DUTY_W   = 8,
   parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic                i_en;
   logic                i_duty_we;
   logic [SEL_W-1:0]    i_duty_sel;
   logic [DUTY_W-1:0]   i_duty_wdata;
   logic [CHANNELS-1:0] i_ch_en;
   logic [CHANNELS-1:0] o_pwm_out;
   logic                o_frame_start;
   logic [CHANNELS-1:0] o_upd_pending;

   modport master (
      output i_en, i_duty_we, i_duty_sel, i_duty_wdata, i_ch_en,
      input  o_pwm_out, o_frame_start, o_upd_pending
   );

   modport slave (
      input  i_en, i_duty_we, i_duty_sel, i_duty_wdata, i_ch_en,
      output o_pwm_out, o_frame_start, o_upd_pending
   );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo pulse generator: one shared frame counter, double-buffered duty commands
// applied at frame boundaries, one MIN..MAX pulse per channel per frame.
module servo_pwm_multi #(
   parameter int unsigned CLK_HZ     = 25000000,
   parameter int unsigned FRAME_HZ   = 50,
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned DUTY_W     = 8,
   parameter int unsigned MIN_US     = 1000,
   parameter int unsigned MAX_US     = 2000,
   parameter int unsigned DUTY_RESET = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   servo_pwm_multi_if.slave   bus
);

   localparam int unsigned FRAME_CLKS = CLK_HZ / FRAME_HZ;
   localparam int unsigned CLK_PER_US = CLK_HZ / 1000000;
   localparam int unsigned MIN_CLKS   = CLK_PER_US * MIN_US;
   localparam int unsigned MAX_CLKS   = CLK_PER_US * MAX_US;
   localparam int unsigned SPAN_CLKS  = MAX_CLKS - MIN_CLKS;
   localparam int unsigned CNT_W      = $clog2(FRAME_CLKS);
   localparam int unsigned PROD_W     = DUTY_W + $clog2(SPAN_CLKS + 1);
   localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   if (!((MAX_CLKS > MIN_CLKS) && (MAX_CLKS < FRAME_CLKS))) begin : g_bad_cfg
      $error("servo_pwm_multi: require MIN_CLKS < MAX_CLKS < FRAME_CLKS");
   end

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e              r_state, w_state_d;
   logic [CNT_W-1:0]    r_cnt, w_cnt_d;
   logic [DUTY_W-1:0]   r_staged [CHANNELS];
   logic [DUTY_W-1:0]   r_active [CHANNELS];
   logic [DUTY_W-1:0]   w_act_duty_d [CHANNELS];
   logic [CHANNELS-1:0] r_act_en, w_act_en_d;
   logic [CHANNELS-1:0] r_pending, w_pend_d;
   logic [CHANNELS-1:0] r_pwm, w_pwm_d;
   logic                r_frame_start, w_frame_start_d;
   logic [PROD_W-1:0]   w_prod [CHANNELS];
   logic [CNT_W-1:0]    w_width [CHANNELS];
   logic                w_latch;
   logic                w_wr_hit;

   // Outputs are registered, so they are computed from the counter value one edge ahead:
   // the edge that latches the new frame's settings also raises frame_start and the pulses.
   assign w_latch  = (r_state == StRun) && bus.i_en && (r_cnt == '0);
   assign w_wr_hit = bus.i_duty_we && (32'(bus.i_duty_sel) < CHANNELS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (bus.i_en)  w_state_d = StRun;
         StRun:   if (!bus.i_en) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_frame_start_d = w_latch;
      for (int i = 0; i < CHANNELS; i++) begin
         w_pwm_d[i] = (r_state == StRun) && (w_state_d == StRun) && w_act_en_d[i] &&
                      (r_cnt < w_width[i]);
      end
   end

   always_comb begin
      w_cnt_d = '0;
      if ((r_state == StRun) && (w_state_d == StRun)) begin
         w_cnt_d = (r_cnt == CNT_W'(FRAME_CLKS - 1)) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_act_duty_d = r_active;
      w_act_en_d   = r_act_en;
      if (w_latch) begin
         w_act_duty_d = r_staged;
         w_act_en_d   = bus.i_ch_en;
      end
      for (int i = 0; i < CHANNELS; i++) begin
         w_prod[i]  = PROD_W'(w_act_duty_d[i]) * PROD_W'(SPAN_CLKS);
         w_width[i] = CNT_W'(MIN_CLKS) + CNT_W'(w_prod[i] >> DUTY_W);
      end
   end

   // A write on the latching edge keeps its pending flag: it targets the following frame.
   always_comb begin
      w_pend_d = w_latch ? '0 : r_pending;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_wr_hit && (bus.i_duty_sel == SEL_W'(i))) w_pend_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_act_en      <= '0;
         r_pending     <= '0;
         r_pwm         <= '0;
         r_frame_start <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_staged[i] <= DUTY_W'(DUTY_RESET);
            r_active[i] <= DUTY_W'(DUTY_RESET);
         end
      end else begin
         r_cnt         <= w_cnt_d;
         r_act_en      <= w_act_en_d;
         r_pending     <= w_pend_d;
         r_pwm         <= w_pwm_d;
         r_frame_start <= w_frame_start_d;
         r_active      <= w_act_duty_d;
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_wr_hit && (bus.i_duty_sel == SEL_W'(i))) r_staged[i] <= bus.i_duty_wdata;
         end
      end
   end

   assign bus.o_pwm_out     = r_pwm;
   assign bus.o_frame_start = r_frame_start;
   assign bus.o_upd_pending = r_pending;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a scaled clock: 500-clk frames, 100..200-clk pulses,
// five channels so that duty_sel=5 is an out-of-range index.
module tb_servo_pwm_multi;

   localparam int unsigned CLK_HZ   = 1000000;
   localparam int unsigned FRAME_HZ = 2000;
   localparam int unsigned NCH      = 5;
   localparam int unsigned DUTY_W   = 8;
   localparam int unsigned FRAME    = CLK_HZ / FRAME_HZ;

   // Hand-computed widths: 100 + (duty*100 >> 8)
   localparam int W0   = 100;
   localparam int W64  = 125;
   localparam int W128 = 150;
   localparam int W200 = 178;
   localparam int W255 = 199;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   int   hi_cnt [NCH];
   logic [NCH-1:0] late_rise;

   servo_pwm_multi_if #(.CHANNELS(NCH), .DUTY_W(DUTY_W)) bus_if ();

   servo_pwm_multi #(
      .CLK_HZ     (CLK_HZ),
      .FRAME_HZ   (FRAME_HZ),
      .CHANNELS   (NCH),
      .DUTY_W     (DUTY_W),
      .MIN_US     (100),
      .MAX_US     (200),
      .DUTY_RESET (128)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fs(input string tag);
      int n;
      n = 0;
      do begin
         step();
         bus_if.i_duty_we = 1'b0;
         n++;
      end while (!bus_if.o_frame_start && n < int'(FRAME) + 10);
      check_eq(tag, 32'(bus_if.o_frame_start), 32'd1);
   endtask

   task automatic action(input int code, input int c);
      bus_if.i_duty_we = 1'b0;
      case (code)
         1: begin
            if (c == 100) begin
               bus_if.i_duty_we = 1'b1; bus_if.i_duty_sel = 3'd0; bus_if.i_duty_wdata = 8'd0;
            end
            if (c == 101) begin
               bus_if.i_duty_we = 1'b1; bus_if.i_duty_sel = 3'd1; bus_if.i_duty_wdata = 8'd255;
            end
            if (c == 102) begin
               bus_if.i_duty_we = 1'b1; bus_if.i_duty_sel = 3'd2; bus_if.i_duty_wdata = 8'd64;
            end
            if (c == 110) check_eq("pend_after_wr", 32'(bus_if.o_upd_pending), 32'b00111);
         end
         2: if (c == 0) check_eq("pend_clr", 32'(bus_if.o_upd_pending), 32'd0);
         3: if (c == int'(FRAME) - 1) begin
            bus_if.i_duty_we = 1'b1; bus_if.i_duty_sel = 3'd3; bus_if.i_duty_wdata = 8'd200;
         end
         4: if (c == 0) check_eq("pend_edge_wr", 32'(bus_if.o_upd_pending), 32'b01000);
         5: begin
            if (c == 0) check_eq("pend_clr2", 32'(bus_if.o_upd_pending), 32'd0);
            if (c == 20) bus_if.i_ch_en = 5'b11011;
         end
         6: if (c == 10) bus_if.i_ch_en = 5'b11111;
         default: ;
      endcase
   endtask

   // Entered at the sample point of frame cycle 0; leaves at the sample point of the last cycle.
   task automatic measure(input int code);
      logic [NCH-1:0] prev;
      prev      = '0;
      late_rise = '0;
      for (int i = 0; i < int'(NCH); i++) hi_cnt[i] = 0;
      for (int c = 0; c < int'(FRAME); c++) begin
         if (c > 0) step();
         for (int i = 0; i < int'(NCH); i++) begin
            if (bus_if.o_pwm_out[i]) begin
               hi_cnt[i]++;
               if (!prev[i] && c > 0) late_rise[i] = 1'b1;
            end
            prev[i] = bus_if.o_pwm_out[i];
         end
         action(code, c);
      end
   endtask

   task automatic check_widths(input string tag, input int e0, input int e1, input int e2,
                               input int e3, input int e4);
      int e [NCH];
      e = '{e0, e1, e2, e3, e4};
      for (int i = 0; i < int'(NCH); i++) begin
         check_eq($sformatf("%s_w%0d", tag, i), 32'(hi_cnt[i]), 32'(e[i]));
      end
      check_eq($sformatf("%s_glitch", tag), 32'(late_rise), 32'd0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus_if.i_en         = 1'b0;
      bus_if.i_duty_we    = 1'b0;
      bus_if.i_duty_sel   = '0;
      bus_if.i_duty_wdata = '0;
      bus_if.i_ch_en      = '0;
      repeat (3) step();
      check_eq("rst_pwm", 32'(bus_if.o_pwm_out), 32'd0);
      check_eq("rst_fs", 32'(bus_if.o_frame_start), 32'd0);
      check_eq("rst_pend", 32'(bus_if.o_upd_pending), 32'd0);

      rst_n = 1'b1;
      bus_if.i_en    = 1'b1;
      bus_if.i_ch_en = 5'b11111;

      // Default duty on every channel
      wait_fs("fs_a");  measure(0); check_widths("frm_a", W128, W128, W128, W128, W128);
      // Mid-frame writes do not touch the running frame
      wait_fs("fs_b");  measure(1); check_widths("frm_b", W128, W128, W128, W128, W128);
      wait_fs("fs_c");  measure(2); check_widths("frm_c", W0, W255, W64, W128, W128);
      // Write on the latching edge goes to the frame after next
      wait_fs("fs_d");  measure(3); check_widths("frm_d", W0, W255, W64, W128, W128);
      wait_fs("fs_e");  measure(4); check_widths("frm_e", W0, W255, W64, W128, W128);
      // ch_en[2] dropped mid-pulse
      wait_fs("fs_f");  measure(5); check_widths("frm_f", W0, W255, W64, W200, W128);
      wait_fs("fs_g");  measure(6); check_widths("frm_g", W0, W255, 0, W200, W128);

      // Enable dropped mid-frame, then re-enabled
      wait_fs("fs_h");
      for (int c = 1; c <= 50; c++) step();
      check_eq("en_pre_pwm", 32'(bus_if.o_pwm_out), 32'b11111);
      bus_if.i_en = 1'b0;
      step();
      check_eq("en_off_pwm", 32'(bus_if.o_pwm_out), 32'd0);
      check_eq("en_off_fs", 32'(bus_if.o_frame_start), 32'd0);
      repeat (5) step();
      check_eq("idle_pwm", 32'(bus_if.o_pwm_out), 32'd0);
      bus_if.i_en = 1'b1;
      step();
      check_eq("reen_fs0", 32'(bus_if.o_frame_start), 32'd0);
      step();
      check_eq("reen_fs1", 32'(bus_if.o_frame_start), 32'd1);
      measure(0); check_widths("frm_re", W0, W255, W64, W200, W128);

      // Out-of-range channel index
      wait_fs("fs_i");
      for (int c = 1; c <= 10; c++) step();
      bus_if.i_duty_we    = 1'b1;
      bus_if.i_duty_sel   = 3'd5;
      bus_if.i_duty_wdata = 8'd0;
      step();
      bus_if.i_duty_we = 1'b0;
      check_eq("badsel_pend", 32'(bus_if.o_upd_pending), 32'd0);
      wait_fs("fs_j");  measure(0); check_widths("frm_j", W0, W255, W64, W200, W128);

      // Asynchronous reset in the middle of a pulse
      wait_fs("fs_k");
      for (int c = 1; c <= 20; c++) step();
      check_eq("prerst_pwm", 32'(bus_if.o_pwm_out), 32'b11111);
      rst_n = 1'b0;
      #1;
      check_eq("arst_pwm", 32'(bus_if.o_pwm_out), 32'd0);
      check_eq("arst_fs", 32'(bus_if.o_frame_start), 32'd0);
      check_eq("arst_pend", 32'(bus_if.o_upd_pending), 32'd0);
      step();
      rst_n = 1'b1;
      wait_fs("fs_l");  measure(0); check_widths("frm_l", W128, W128, W128, W128, W128);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
